// File: rtl/register_fifo_mode.sv
// Per-instance configurable datapath register: constant, bypass, one-cycle delay or
// DEPTH-entry valid/ready FIFO, with a config-bus write into the word at the read pointer.
module register_fifo_mode #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    input  logic                       clk_en,
    input  logic [1:0]                 mode,
    input  logic                       config_we,
    input  logic [WIDTH-1:0]           config_data,
    input  logic [WIDTH-1:0]           const_,
    input  logic [WIDTH-1:0]           value,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           O0,
    output logic [WIDTH-1:0]           O1,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_BYPASS = 2'd1;
    localparam logic [1:0] MODE_DELAY  = 2'd2;
    localparam logic [1:0] MODE_FIFO   = 2'd3;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign O1         = mem_q[rd_ptr_q];
    assign count      = cnt_q;

    // Mode-dependent datapath outputs; only BYPASS has a path from inputs to handshakes
    always_comb begin
        O0        = mem_q[rd_ptr_q];
        valid_out = 1'b1;
        ready_out = 1'b1;
        case (mode)
            MODE_CONST: begin
                O0 = const_;
            end
            MODE_BYPASS: begin
                O0        = value;
                valid_out = valid_in;
                ready_out = ready_in;
            end
            MODE_DELAY: begin
                O0 = mem_q[rd_ptr_q];
            end
            default: begin
                valid_out = !fifo_empty;
                ready_out = !fifo_full;
            end
        endcase
    end

    assign push = (mode == MODE_FIFO) && valid_in && !fifo_full && clk_en;
    assign pop  = (mode == MODE_FIFO) && !fifo_empty && ready_in && clk_en;

    // Next state: config write overrides every datapath update and ignores clk_en
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (config_we) begin
            mem_d[rd_ptr_q] = config_data;
            if (mode == MODE_FIFO) begin
                cnt_d    = CW'(1);
                wr_ptr_d = rd_ptr_q + PW'(1);
            end
        end else if (clk_en) begin
            if (mode == MODE_DELAY) begin
                mem_d[rd_ptr_q] = value;
            end
            if (push) begin
                mem_d[wr_ptr_q] = value;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_register_fifo_mode.sv
// Directed bench for register_fifo_mode (WIDTH=16, DEPTH=4) with hand-computed expectations.
module tb_register_fifo_mode;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic              CLK = 1'b0;
    logic              ASYNCRESET;
    logic              clk_en;
    logic [1:0]        mode;
    logic              config_we;
    logic [WIDTH-1:0]  config_data;
    logic [WIDTH-1:0]  const_;
    logic [WIDTH-1:0]  value;
    logic              valid_in;
    logic              ready_out;
    logic              ready_in;
    logic              valid_out;
    logic [WIDTH-1:0]  O0;
    logic [WIDTH-1:0]  O1;
    logic [2:0]        count;

    int n_cmp = 0;
    int n_bad = 0;

    register_fifo_mode #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .clk_en(clk_en), .mode(mode),
        .config_we(config_we), .config_data(config_data), .const_(const_),
        .value(value), .valid_in(valid_in), .ready_out(ready_out),
        .ready_in(ready_in), .valid_out(valid_out), .O0(O0), .O1(O1), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [WIDTH-1:0] exp_seq [6];
    initial begin
        exp_seq[0] = 16'd1; exp_seq[1] = 16'd2; exp_seq[2] = 16'd3;
        exp_seq[3] = 16'd4; exp_seq[4] = 16'd9; exp_seq[5] = 16'd9;
    end

    initial begin
        ASYNCRESET  = 1'b1;
        clk_en      = 1'b1;
        mode        = 2'd3;
        config_we   = 1'b0;
        config_data = '0;
        const_      = '0;
        value       = '0;
        valid_in    = 1'b0;
        ready_in    = 1'b0;
        #12;
        ASYNCRESET = 1'b0;
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid_out", 32'(valid_out), 32'd0);
        check_eq("rst_ready_out", 32'(ready_out), 32'd1);
        check_eq("rst_O1", 32'(O1), 32'd0);
        check_eq("rst_O0", 32'(O0), 32'd0);

        // Fill with 1..4 while downstream stalls
        valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            value = 16'(i);
            tick();
        end
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_ready_out", 32'(ready_out), 32'd0);
        check_eq("full_O0", 32'(O0), 32'd1);
        value = 16'd5;
        tick();
        check_eq("fifth_rejected_count", 32'(count), 32'd4);

        // Drain from full while upstream keeps offering 9
        value    = 16'd9;
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("order_%0d", i), 32'(O0), 32'(exp_seq[i]));
            tick();
        end
        check_eq("stream_count", 32'(count), 32'd3);

        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("drained_count", 32'(count), 32'd0);
        check_eq("drained_valid_out", 32'(valid_out), 32'd0);

        // Empty: no fall-through
        valid_in = 1'b1;
        value    = 16'd7;
        #1;
        check_eq("nofallthru_valid_out", 32'(valid_out), 32'd0);
        tick();
        check_eq("push7_O0", 32'(O0), 32'd7);
        check_eq("push7_valid_out", 32'(valid_out), 32'd1);
        check_eq("push7_count", 32'(count), 32'd1);
        value = 16'd8;
        tick();
        check_eq("pushpop_count", 32'(count), 32'd1);
        check_eq("pushpop_O0", 32'(O0), 32'd8);

        // Build count=3, then config write drops the concurrent push
        ready_in = 1'b0;
        value = 16'h11; tick();
        value = 16'h12; tick();
        check_eq("pre_cfg_count", 32'(count), 32'd3);
        config_we   = 1'b1;
        config_data = 16'h3C;
        value       = 16'h99;
        ready_in    = 1'b1;
        tick();
        config_we = 1'b0;
        valid_in  = 1'b0;
        ready_in  = 1'b0;
        check_eq("cfg_count", 32'(count), 32'd1);
        check_eq("cfg_O0", 32'(O0), 32'h3C);
        check_eq("cfg_O1", 32'(O1), 32'h3C);
        check_eq("cfg_valid_out", 32'(valid_out), 32'd1);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check_eq("cfg_push_dropped", 32'(count), 32'd0);

        // DELAY mode
        mode  = 2'd2;
        value = 16'hA;
        tick();
        check_eq("delay_A", 32'(O0), 32'hA);
        value = 16'hB;
        tick();
        check_eq("delay_B", 32'(O0), 32'hB);
        check_eq("delay_count", 32'(count), 32'd0);
        clk_en = 1'b0;
        value  = 16'hC;
        tick();
        check_eq("delay_hold", 32'(O0), 32'hB);
        config_we   = 1'b1;
        config_data = 16'h5;
        tick();
        config_we = 1'b0;
        check_eq("delay_cfg_O0", 32'(O0), 32'h5);
        check_eq("delay_cfg_O1", 32'(O1), 32'h5);
        clk_en = 1'b1;

        // CONST and BYPASS
        mode   = 2'd0;
        const_ = 16'h77;
        #1;
        check_eq("const_O0", 32'(O0), 32'h77);
        check_eq("const_valid_out", 32'(valid_out), 32'd1);
        check_eq("const_ready_out", 32'(ready_out), 32'd1);
        tick();
        check_eq("const_count", 32'(count), 32'd0);
        mode     = 2'd1;
        value    = 16'h1234;
        valid_in = 1'b1;
        ready_in = 1'b0;
        #1;
        check_eq("byp_O0_a", 32'(O0), 32'h1234);
        check_eq("byp_valid_a", 32'(valid_out), 32'd1);
        check_eq("byp_ready_a", 32'(ready_out), 32'd0);
        value    = 16'h4321;
        valid_in = 1'b0;
        ready_in = 1'b1;
        #1;
        check_eq("byp_O0_b", 32'(O0), 32'h4321);
        check_eq("byp_valid_b", 32'(valid_out), 32'd0);
        check_eq("byp_ready_b", 32'(ready_out), 32'd1);

        // Reset in the middle of a FIFO stream
        mode     = 2'd3;
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value = 16'(16'h20 + i);
            tick();
        end
        check_eq("prerst_count", 32'(count), 32'd3);
        #1;
        ASYNCRESET = 1'b1;
        #1;
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_valid_out", 32'(valid_out), 32'd0);
        check_eq("midrst_ready_out", 32'(ready_out), 32'd1);
        check_eq("midrst_O0", 32'(O0), 32'd0);
        check_eq("midrst_O1", 32'(O1), 32'd0);
        ASYNCRESET = 1'b0;
        valid_in   = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_fifo_mode.md
# register_fifo_mode

Parametrised successor to the single-word mode register in the CGRA routing/PE datapath. Each instance selects one of four behaviours per configuration: constant, combinational bypass, one-cycle register, or a DEPTH-entry valid/ready FIFO. It sits between an upstream and a downstream tile port. It provides a config-bus write path and a readback of the stored word.

## Interface
Parameters:
- WIDTH, 16, data word width (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2; pointer width PW = log2(DEPTH)

Ports:
- CLK  in  1  clock, rising edge
- ASYNCRESET  in  1  asynchronous, active-high reset
- clk_en  in  1  state-update enable (does not gate config writes)
- mode  in  2  0=CONST, 1=BYPASS, 2=DELAY, 3=FIFO
- config_we  in  1  config write strobe
- config_data  in  WIDTH  config write data
- const_  in  WIDTH  constant value for CONST mode
- value  in  WIDTH  upstream data
- valid_in  in  1  upstream valid
- ready_out  out  1  ready to upstream
- ready_in  in  1  downstream ready
- valid_out  out  1  valid to downstream
- O0  out  WIDTH  data to downstream
- O1  out  WIDTH  readback: mem[rd_ptr]
- count  out  PW+1  FIFO occupancy, 0..DEPTH

## Operation
State: mem[0..DEPTH-1] (WIDTH each), rd_ptr and wr_ptr (PW bits, wrap modulo DEPTH), cnt (PW+1 bits). On reset all state is 0.

Outputs by mode (combinational from state and inputs):
- CONST: O0=const_, valid_out=1, ready_out=1. State is untouched; inputs are accepted and discarded.
- BYPASS: O0=value, valid_out=valid_in, ready_out=ready_in. State is untouched.
- DELAY: O0=mem[rd_ptr], valid_out=1, ready_out=1. If clk_en=1, mem[rd_ptr]<=value every cycle, regardless of valid_in.
- FIFO:
  - O0=mem[rd_ptr], valid_out=(cnt!=0), ready_out=(cnt!=DEPTH).
  - push = valid_in & ready_out & clk_en: mem[wr_ptr]<=value, wr_ptr++.
  - pop = valid_out & ready_in & clk_en: rd_ptr++.
  - cnt updates +1 on push only, -1 on pop only, unchanged on both or neither.
  - When empty there is no fall-through: a pushed word is first visible the next cycle.
  - When full, ready_out=0, so a simultaneous pop does not enable a push that cycle.
- O1=mem[rd_ptr] in all modes. count=cnt in all modes.

Config write has the highest priority and applies even when clk_en=0. If config_we=1:
- mem[rd_ptr]<=config_data.
- In FIFO mode, additionally cnt<=1 and wr_ptr<=rd_ptr+1. The FIFO is flushed and preloaded with a single word.
- All push, pop and DELAY updates are suppressed that cycle.
- In other modes the pointers and cnt are unchanged.

clk_en=0 and config_we=0: all state is frozen and outputs stay combinational. In FIFO mode valid_out and ready_out still reflect cnt; no transfer occurs, and upstream/downstream must treat the handshake as not completed. Owners gate the handshake with clk_en externally.

Mode changes do not flush: pointers, cnt and mem persist. Re-entering FIFO resumes with the prior contents.

Reset mid-operation: asynchronous clear of all state; outputs settle within the same cycle. After reset in FIFO mode: valid_out=0, ready_out=1, count=0, O0=O1=0.

## Timing
- CONST and BYPASS: zero latency, purely combinational.
- DELAY: O0 at cycle n+1 equals value sampled at the edge ending cycle n (when clk_en=1).
- FIFO: push-to-valid_out latency is 1 cycle. Sustained throughput is 1 word/cycle when neither full nor empty stalls.
- Config write is visible on O1/O0 the cycle after config_we.
- No combinational path from ready_in to ready_out or from valid_in to valid_out, except in BYPASS.

## Test plan
- Reset, mode=3, DEPTH=4: release ASYNCRESET -> count=0, valid_out=0, ready_out=1, O1=0. Push 1,2,3,4 on consecutive cycles with ready_in=0 -> count=4, ready_out=0. A 5th push of 5 is not accepted.
- FIFO full, valid_in=1 value=9, ready_in=1 for 6 cycles -> pops 1,2,3,4 on the first four edges. Pointers wrap. Output order is 1,2,3,4,9,9. No push occurs the first cycle (full).
- FIFO empty, push 7 with ready_in=1 -> valid_out=0 on the push cycle; next cycle O0=7, valid_out=1, count=1. Simultaneous push 8 and pop keeps count=1.
- mode=2, clk_en=1, value 0xA then 0xB -> O0 shows 0xA, then 0xB, one cycle delayed. With clk_en=0, O0 holds. config_we with config_data=0x5 while clk_en=0 -> O0=O1=0x5 next cycle.
- mode=3 with count=3, config_we=1, config_data=0x3C -> next cycle count=1, O0=0x3C, valid_out=1. The push asserted that same cycle is dropped.
- mode=0, const_=0x77 -> O0=0x77, valid_out=1, count unchanged. mode=1 -> O0 tracks value, valid_out=valid_in, ready_out=ready_in. Assert ASYNCRESET mid-FIFO-stream -> count=0 immediately, without waiting for CLK.
